// File: rtl/bp_lce_mem_port_arbiter_if.sv
// Bundle between LCE-side requesters, the port arbiter and one cache memory packet port.
// The arbiter uses the master view; requester/cache models use the slave view.
interface bp_lce_mem_port_arbiter_if #(
    parameter int unsigned num_req_p   = 2,
    parameter int unsigned pkt_width_p = 8
);
    localparam int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [num_req_p*pkt_width_p-1:0] req_pkt;
    logic [num_req_p-1:0]             req_v;
    logic [num_req_p-1:0]             req_lock;
    logic [num_req_p-1:0]             req_yumi;
    logic [pkt_width_p-1:0]           pkt;
    logic                             pkt_v;
    logic                             pkt_yumi;
    logic [lg_num_req_lp-1:0]         grant_id;
    logic                             locked;
    logic                             blocked;

    modport master (
        input  req_pkt, req_v, req_lock, pkt_yumi,
        output req_yumi, pkt, pkt_v, grant_id, locked, blocked
    );

    modport slave (
        output req_pkt, req_v, req_lock, pkt_yumi,
        input  req_yumi, pkt, pkt_v, grant_id, locked, blocked
    );
endinterface

// File: rtl/bp_lce_mem_port_arbiter.sv
// Round-robin arbiter sharing one cache mem packet port between LCE engines, with
// stall hold, locked multi-packet sequences and a stall-timeout blocked flag.
module bp_lce_mem_port_arbiter #(
    parameter int unsigned num_req_p           = 2,
    parameter int unsigned pkt_width_p         = 8,
    parameter int unsigned timeout_max_limit_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    bp_lce_mem_port_arbiter_if.master       bus
);
    localparam int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned cnt_width_lp  =
        (timeout_max_limit_p > 0) ? $clog2(timeout_max_limit_p + 1) : 1;

    typedef logic [lg_num_req_lp-1:0] id_t;
    typedef logic [cnt_width_lp-1:0]  cnt_t;

    localparam id_t  last_id_lp = id_t'(num_req_p - 1);
    localparam cnt_t cnt_max_lp = cnt_t'(timeout_max_limit_p);

    id_t  rr_ptr_q, rr_ptr_d;
    logic hold_q, hold_d;
    id_t  hold_id_q, hold_id_d;
    logic lock_q, lock_d;
    id_t  lock_id_q, lock_id_d;
    cnt_t timeout_cnt_q, timeout_cnt_d;

    id_t                  grant;
    logic                 found;
    logic [31:0]          rr_int;
    logic                 pkt_v_raw;
    logic [num_req_p-1:0] grant_sel;
    logic                 yumi;
    logic                 stall;
    logic                 grant_lock;

    function automatic id_t inc_wrap(id_t x);
        return (x == last_id_lp) ? id_t'(0) : id_t'(x + id_t'(1));
    endfunction

    assign rr_int = 32'(rr_ptr_q);

    // Lock beats hold beats the round-robin scan starting at rr_ptr_q.
    always_comb begin
        grant = rr_ptr_q;
        found = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (hold_q) begin
            grant = hold_id_q;
        end else begin
            for (int unsigned k = 0; k < num_req_p; k++) begin
                for (int unsigned i = 0; i < num_req_p; i++) begin
                    if (!found && bus.req_v[i] && (((rr_int + k) % num_req_p) == i)) begin
                        grant = id_t'(i);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pkt_v_raw = 1'b0;
        bus.pkt   = '0;
        grant_sel = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant == id_t'(i)) begin
                pkt_v_raw    = bus.req_v[i];
                bus.pkt      = bus.req_pkt[i*pkt_width_p +: pkt_width_p];
                grant_sel[i] = 1'b1;
            end
        end
    end

    assign yumi         = pkt_v_raw & bus.pkt_yumi & ~reset_i;
    assign stall        = pkt_v_raw & ~bus.pkt_yumi;
    assign grant_lock   = |(grant_sel & bus.req_lock);
    assign bus.pkt_v    = pkt_v_raw & ~reset_i;
    assign bus.req_yumi = yumi ? grant_sel : '0;
    assign bus.grant_id = reset_i ? id_t'(0) : grant;
    assign bus.locked   = lock_q & ~reset_i;
    assign bus.blocked  = (timeout_cnt_q == cnt_max_lp) & ~reset_i;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        hold_d        = stall;
        hold_id_d     = hold_id_q;
        lock_d        = lock_q;
        lock_id_d     = lock_id_q;
        timeout_cnt_d = '0;

        // A held grantee that drops valid simply falls out of hold here.
        if (stall) begin
            hold_id_d     = grant;
            timeout_cnt_d = (timeout_cnt_q == cnt_max_lp) ? timeout_cnt_q
                                                          : cnt_t'(timeout_cnt_q + cnt_t'(1));
        end

        if (yumi) begin
            if (grant_lock) begin
                lock_d    = 1'b1;
                lock_id_d = grant;
            end else if (lock_q) begin
                lock_d   = 1'b0;
                rr_ptr_d = inc_wrap(lock_id_q);
            end else begin
                rr_ptr_d = inc_wrap(grant);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q      <= '0;
            hold_q        <= 1'b0;
            hold_id_q     <= '0;
            lock_q        <= 1'b0;
            lock_id_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            hold_q        <= hold_d;
            hold_id_q     <= hold_id_d;
            lock_q        <= lock_d;
            lock_id_q     <= lock_id_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
endmodule

// File: tb/tb_bp_lce_mem_port_arbiter.sv
// Vector-table bench for the port arbiter: a 4-requester instance (timeout 4) and a
// 2-requester instance (timeout 2); expectations queued on drive, compared mid-cycle.
module tb_bp_lce_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    bp_lce_mem_port_arbiter_if #(.num_req_p(4), .pkt_width_p(8)) bus4 ();
    bp_lce_mem_port_arbiter_if #(.num_req_p(2), .pkt_width_p(8)) bus2 ();

    bp_lce_mem_port_arbiter #(
        .num_req_p(4), .pkt_width_p(8), .timeout_max_limit_p(4)
    ) dut4 (
        .clk_i(clk), .reset_i(rst4), .bus(bus4)
    );

    bp_lce_mem_port_arbiter #(
        .num_req_p(2), .pkt_width_p(8), .timeout_max_limit_p(2)
    ) dut2 (
        .clk_i(clk), .reset_i(rst2), .bus(bus2)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] rv;
        logic [3:0] lk_in;
        logic       yumi;
        logic [1:0] gid;
        logic       pv;
        logic [3:0] ry;
        logic       lk;
        logic       bl;
    } vec_t;

    vec_t vecs4 [37];
    vec_t vecs2 [10];
    vec_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic [3:0] rv, logic [3:0] li, logic y,
                                logic [1:0] g, logic pv, logic [3:0] ry, logic lk, logic bl);
        return '{rst: r, rv: rv, lk_in: li, yumi: y, gid: g, pv: pv, ry: ry, lk: lk, bl: bl};
    endfunction

    task automatic chk(string nm, int row, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic step4(int row);
        vec_t e;
        @(posedge clk);
        #1;
        rst4          = vecs4[row].rst;
        bus4.req_v    = vecs4[row].rv;
        bus4.req_lock = vecs4[row].lk_in;
        bus4.pkt_yumi = vecs4[row].yumi;
        exp_q.push_back(vecs4[row]);
        #4;
        e = exp_q.pop_front();
        chk("dut4.pkt_v", row, {7'b0, bus4.pkt_v}, {7'b0, e.pv});
        chk("dut4.req_yumi", row, {4'b0, bus4.req_yumi}, {4'b0, e.ry});
        chk("dut4.locked", row, {7'b0, bus4.locked}, {7'b0, e.lk});
        chk("dut4.blocked", row, {7'b0, bus4.blocked}, {7'b0, e.bl});
        if (e.pv || e.rst) chk("dut4.grant_id", row, {6'b0, bus4.grant_id}, {6'b0, e.gid});
        if (e.pv) chk("dut4.pkt", row, bus4.pkt, 8'hA0 | {6'b0, e.gid});
    endtask

    task automatic step2(int row);
        vec_t e;
        @(posedge clk);
        #1;
        rst2          = vecs2[row].rst;
        bus2.req_v    = vecs2[row].rv[1:0];
        bus2.req_lock = vecs2[row].lk_in[1:0];
        bus2.pkt_yumi = vecs2[row].yumi;
        exp_q.push_back(vecs2[row]);
        #4;
        e = exp_q.pop_front();
        chk("dut2.pkt_v", row, {7'b0, bus2.pkt_v}, {7'b0, e.pv});
        chk("dut2.req_yumi", row, {6'b0, bus2.req_yumi}, {4'b0, e.ry});
        chk("dut2.locked", row, {7'b0, bus2.locked}, {7'b0, e.lk});
        chk("dut2.blocked", row, {7'b0, bus2.blocked}, {7'b0, e.bl});
        if (e.pv || e.rst) chk("dut2.grant_id", row, {7'b0, bus2.grant_id}, {6'b0, e.gid});
        if (e.pv) chk("dut2.pkt", row, bus2.pkt, 8'hB0 | {6'b0, e.gid});
    endtask

    initial begin
        //                rst rv       lk_in    y  gid  pv ry       lk bl
        vecs4[0]  = mk(1, 4'b0011, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 0);
        // Two requesters, yumi every cycle: strict alternation.
        vecs4[1]  = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[2]  = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        vecs4[3]  = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[4]  = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        // Stall holds grant 0 while req1 arrives; req1 goes right after.
        vecs4[5]  = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs4[6]  = mk(0, 4'b0011, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs4[7]  = mk(0, 4'b0011, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs4[8]  = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[9]  = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        // Locked 4-packet burst from req0 with req1 waiting.
        vecs4[10] = mk(0, 4'b0011, 4'b0001, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[11] = mk(0, 4'b0011, 4'b0001, 1, 2'd0, 1, 4'b0001, 1, 0);
        vecs4[12] = mk(0, 4'b0011, 4'b0001, 1, 2'd0, 1, 4'b0001, 1, 0);
        vecs4[13] = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 1, 0);
        vecs4[14] = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        // Locked owner goes idle: nobody else gets in.
        vecs4[15] = mk(0, 4'b0011, 4'b0001, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[16] = mk(0, 4'b0010, 4'b0000, 1, 2'd0, 0, 4'b0000, 1, 0);
        vecs4[17] = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 1, 0);
        // Starved port: blocked after four stalled cycles, cleared after one yumi.
        vecs4[18] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 0);
        vecs4[19] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 0);
        vecs4[20] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 0);
        vecs4[21] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 0);
        vecs4[22] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 1);
        vecs4[23] = mk(0, 4'b0010, 4'b0000, 0, 2'd1, 1, 4'b0000, 0, 1);
        vecs4[24] = mk(0, 4'b0010, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 1);
        vecs4[25] = mk(0, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 0, 0);
        // Pointer at 3, only req1 valid: wrap to 1, pointer then 2.
        vecs4[26] = mk(0, 4'b0100, 4'b0000, 1, 2'd2, 1, 4'b0100, 0, 0);
        vecs4[27] = mk(0, 4'b0010, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        vecs4[28] = mk(0, 4'b0110, 4'b0000, 1, 2'd2, 1, 4'b0100, 0, 0);
        // Held grantee drops valid: no yumi, arbitration reopens.
        vecs4[29] = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs4[30] = mk(0, 4'b0010, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 0);
        vecs4[31] = mk(0, 4'b0010, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        // Reset while locked to req2 and stalled.
        vecs4[32] = mk(0, 4'b0100, 4'b0100, 1, 2'd2, 1, 4'b0100, 0, 0);
        vecs4[33] = mk(0, 4'b0101, 4'b0100, 0, 2'd2, 1, 4'b0000, 1, 0);
        vecs4[34] = mk(1, 4'b0101, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 0);
        vecs4[35] = mk(0, 4'b0101, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs4[36] = mk(0, 4'b0101, 4'b0000, 1, 2'd2, 1, 4'b0100, 0, 0);

        vecs2[0]  = mk(1, 4'b0011, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 0);
        vecs2[1]  = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs2[2]  = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        vecs2[3]  = mk(0, 4'b0011, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 0);
        vecs2[4]  = mk(0, 4'b0011, 4'b0000, 1, 2'd1, 1, 4'b0010, 0, 0);
        vecs2[5]  = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs2[6]  = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 0);
        vecs2[7]  = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 1);
        vecs2[8]  = mk(0, 4'b0001, 4'b0000, 1, 2'd0, 1, 4'b0001, 0, 1);
        vecs2[9]  = mk(0, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 0, 0);

        bus4.req_pkt  = 32'hA3A2A1A0;
        bus4.req_v    = '0;
        bus4.req_lock = '0;
        bus4.pkt_yumi = 1'b0;
        bus2.req_pkt  = 16'hB1B0;
        bus2.req_v    = '0;
        bus2.req_lock = '0;
        bus2.pkt_yumi = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 37; i++) step4(i);
        for (int i = 0; i < 10; i++) step2(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bp_lce_mem_port_arbiter.md
Name: bp_lce_mem_port_arbiter

Overview:
- Round-robin arbiter that lets several LCE-side engines (command/fill, writeback, sync/init) share one cache memory packet port: tag_mem, data_mem or stat_mem. One instance per port.
- Holds a grant stable while the cache stalls the port.
- Supports locked multi-packet sequences.
- Raises a blocked flag when the cache starves the port. The LCE ORs this flag into cache_req_busy_o.

Parameters:
- num_req_p, 2, number of requesters; must be ≥2.
- pkt_width_p, "inv", width of one cache mem packet.
- timeout_max_limit_p, 4, consecutive stalled cycles before blocked_o asserts.
- lg_num_req_lp, BSG_SAFE_CLOG2(num_req_p), grant id width (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- req_pkt_i  in  num_req_p*pkt_width_p  packet from each requester; requester i occupies slice [i*pkt_width_p +: pkt_width_p].
- req_v_i  in  num_req_p  per-requester valid.
- req_lock_i  in  num_req_p  keep the grant with this requester after the current packet.
- req_yumi_o  out  num_req_p  one-hot consume strobe back to the requester.
- pkt_o  out  pkt_width_p  packet to the cache.
- pkt_v_o  out  1  packet valid to the cache.
- pkt_yumi_i  in  1  cache consumes the packet.
- grant_id_o  out  lg_num_req_lp  index of the requester currently presented.
- locked_o  out  1  arbiter is locked to one owner.
- blocked_o  out  1  stall timeout reached.

Behaviour:
- State: rr_ptr_r (lg_num_req_lp), hold_r (1), hold_id_r (lg_num_req_lp), lock_r (1), lock_id_r (lg_num_req_lp), timeout_cnt_r (BSG_SAFE_CLOG2(timeout_max_limit_p+1)).
- Reset: all state registers cleared to 0.
- During reset the outputs are forced: pkt_v_o=0, req_yumi_o=0, blocked_o=0, locked_o=0, grant_id_o=0.
- Grant selection (combinational), in priority order:
  - lock_r → grant lock_id_r.
  - else hold_r → grant hold_id_r.
  - else the first i with req_v_i[i], scanning rr_ptr_r, rr_ptr_r+1, … with modulo-num_req_p wrap.
- pkt_v_o = req_v_i[grant]. If no request is valid, pkt_v_o=0 and grant_id_o keeps the last computed index (don't-care).
- pkt_o = req_pkt_i slice of the grant.
- req_yumi_o[grant] = pkt_yumi_i & pkt_v_o. All other yumi bits are 0.
- Zero-latency pass-through: a packet can be consumed in the same cycle its valid first arrives.
- Hold:
  - pkt_v_o & ~pkt_yumi_i → hold_r←1, hold_id_r←grant.
  - yumi → hold_r←0.
  - A held grantee that drops req_v_i (protocol violation) clears hold_r the next cycle. Arbitration reopens; no yumi is issued.
- Round-robin pointer:
  - On yumi with lock_r=0 and req_lock_i[grant]=0: rr_ptr_r ← grant+1 (mod num_req_p).
  - Otherwise rr_ptr_r is unchanged.
- Lock:
  - On yumi with req_lock_i[grant]=1: lock_r←1, lock_id_r←grant.
  - On yumi with req_lock_i[grant]=0 while lock_r=1: lock_r←0, rr_ptr_r←lock_id_r+1.
  - While locked, the owner gaining no request simply yields pkt_v_o=0. Other requesters wait; the lock is never broken by them.
  - locked_o = lock_r.
- Timeout:
  - timeout_cnt_r increments while pkt_v_o & ~pkt_yumi_i, saturating at timeout_max_limit_p.
  - It clears to 0 in any cycle where that stall condition is false.
  - blocked_o = (timeout_cnt_r == timeout_max_limit_p), registered-state based (no combinational path from pkt_yumi_i).
- Simultaneous events:
  - Yumi and a new request from another requester in the same cycle: the new request is arbitrated next cycle using the updated rr_ptr_r.
  - Lock set and lock release cannot coincide (a single yumi per cycle).
- Reset mid-transfer: hold and lock are discarded, and there is no yumi in the reset cycle.
- No combinational path from pkt_yumi_i to pkt_v_o or pkt_o.

Test Plan:
- Fairness: num_req_p=2, both req_v_i held 1, pkt_yumi_i=1 every cycle after reset → grant_id_o sequence 0,1,0,1; req_yumi_o = 01,10,01,10.
- Hold on stall: req0 valid, pkt_yumi_i=0 for 3 cycles, req1 raised in cycle 1 → grant stays 0 and pkt_o is unchanged; yumi in cycle 4 goes to req0; req1 is granted in cycle 5.
- Lock: req0 sends 4 packets with req_lock_i[0]=1,1,1,0 while req1 is valid throughout, all yumi → req0 gets 4 consecutive yumis; locked_o=1 for cycles 2-4; req1 is granted on the 5th cycle.
- Timeout: timeout_max_limit_p=4, pkt_v_o=1, pkt_yumi_i=0 → blocked_o rises at cycle 4 and stays 1; a single yumi clears it the next cycle.
- Wrap: num_req_p=4, rr_ptr_r=3, only req1 valid → grant 1; pointer then goes to 2.
- Reset mid-lock: lock_r=1 for req2, assert reset_i 1 cycle → locked_o=0, rr_ptr_r=0; with req0 and req2 both valid, req0 is granted first.
